regbank_wr_arbiter: RTL



---
 rtl/regbank_wr_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/regbank_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_wr_arbiter
//
// Purpose:
//   Shares the single write port of a 2^AW x DW register bank among NREQ
//   requesters with round-robin arbitration. All outputs toward the bank
//   (write, dr, wrData) and the grant pulse are registered. An optional
//   power-up clear sequence zeroes every register before arbitration starts.
//
// Configuration macro:
//   REGARB_CLEAR_EN  - when defined, a CLEAR state writes 0 to addresses
//                      0..2^AW-1 after reset release and holds busy high
//                      until the last clear write is issued. When undefined,
//                      there is no CLEAR state, no clear counter, busy is 0.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   AW    register address width
//   DW    register data width
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   wr_req     in   [NREQ]     per-requester write request (level)
//   wr_dr      in   [NREQ*AW]  destination register, requester i at [i*AW +: AW]
//   wr_data    in   [NREQ*DW]  write data, requester i at [i*DW +: DW]
//   gnt        out  [NREQ]     one-hot registered grant pulse
//   write      out             registered write enable to the bank
//   dr         out  [AW]       registered destination address to the bank
//   wrData     out  [DW]       registered write data to the bank
//   busy       out             high while the clear sequence runs
//   dbg_state  out             current FSM state (ST_ARB=0, ST_CLEAR=1)
//
// Handshake: a requester raises wr_req[i] and holds wr_req/wr_dr/wr_data
// stable until it observes gnt[i] high for one cycle; that cycle is the one in
// which its write is presented to the bank (bank commits on the following
// edge). Keeping wr_req[i] high past the grant counts as a new request.
// -----------------------------------------------------------------------------
module regbank_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      wr_req,
   input  logic [NREQ*AW-1:0]   wr_dr,
   input  logic [NREQ*DW-1:0]   wr_data,
   output logic [NREQ-1:0]      gnt,
   output logic                 write,
   output logic [AW-1:0]        dr,
   output logic [DW-1:0]        wrData,
   output logic                 busy,
   output logic                 dbg_state
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REGARB_CLEAR_EN
   typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t          r_state;
   state_t          w_nxt_state;
   logic [AW-1:0]   r_clr_cnt;
   logic [AW-1:0]   w_nxt_clr_cnt;
   logic            r_busy;
   logic            w_nxt_busy;
`else
   typedef enum logic {ST_ARB = 1'b0} state_t;
`endif

   // registered outputs and round-robin pointer
   logic [NREQ-1:0] r_gnt;
   logic            r_write;
   logic [AW-1:0]   r_dr;
   logic [DW-1:0]   r_wrdata;
   logic [PW-1:0]   r_rr;

   // arbitration and next-value wires
   logic            w_arb_en;
   logic            w_found;
   logic [PW-1:0]   w_winner;
   logic [NREQ-1:0] w_sel_gnt;
   logic [AW-1:0]   w_sel_dr;
   logic [DW-1:0]   w_sel_data;
   logic [NREQ-1:0] w_nxt_gnt;
   logic            w_nxt_write;
   logic [AW-1:0]   w_nxt_dr;
   logic [DW-1:0]   w_nxt_wrdata;
   logic [PW-1:0]   w_nxt_rr;

`ifdef REGARB_CLEAR_EN
   assign w_arb_en  = (r_state == ST_ARB);
   assign busy      = r_busy;
   assign dbg_state = r_state;
`else
   assign w_arb_en  = 1'b1;
   assign busy      = 1'b0;
   assign dbg_state = ST_ARB;
`endif

   assign gnt    = r_gnt;
   assign write  = r_write;
   assign dr     = r_dr;
   assign wrData = r_wrdata;

   // Round-robin search: first pass covers indices rr..NREQ-1, second pass
   // wraps to 0..rr-1. Only the first hit across both passes is taken.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && wr_req[i] && (PW'(i) >= r_rr)) begin
            w_found  = 1'b1;
            w_winner = PW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && wr_req[i] && (PW'(i) < r_rr)) begin
            w_found  = 1'b1;
            w_winner = PW'(i);
         end
      end
   end

   // Winner's slices, selected with constant indices to keep the muxes simple.
   always_comb begin
      w_sel_gnt  = '0;
      w_sel_dr   = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == w_winner) begin
            w_sel_gnt[i] = 1'b1;
            w_sel_dr     = wr_dr[i*AW +: AW];
            w_sel_data   = wr_data[i*DW +: DW];
         end
      end
   end

   // Next-state / next-output logic. dr, wrData and rr hold when idle.
   always_comb begin
      w_nxt_gnt    = '0;
      w_nxt_write  = 1'b0;
      w_nxt_dr     = r_dr;
      w_nxt_wrdata = r_wrdata;
      w_nxt_rr     = r_rr;
`ifdef REGARB_CLEAR_EN
      w_nxt_state   = r_state;
      w_nxt_clr_cnt = r_clr_cnt;
      w_nxt_busy    = r_busy;
      if (r_state == ST_CLEAR) begin
         w_nxt_write   = 1'b1;
         w_nxt_dr      = r_clr_cnt;
         w_nxt_wrdata  = '0;
         w_nxt_clr_cnt = r_clr_cnt + 1'b1;
         // busy drops on the same edge that issues the last clear write
         if (r_clr_cnt == '1) begin
            w_nxt_state = ST_ARB;
            w_nxt_busy  = 1'b0;
         end
      end
`endif
      if (w_arb_en && w_found) begin
         w_nxt_gnt    = w_sel_gnt;
         w_nxt_write  = 1'b1;
         w_nxt_dr     = w_sel_dr;
         w_nxt_wrdata = w_sel_data;
         w_nxt_rr     = (w_winner == PW'(NREQ-1)) ? '0 : (w_winner + PW'(1));
      end
   end

`ifdef REGARB_CLEAR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_busy    <= 1'b1;
      end else begin
         r_state   <= w_nxt_state;
         r_clr_cnt <= w_nxt_clr_cnt;
         r_busy    <= w_nxt_busy;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt    <= '0;
         r_write  <= 1'b0;
         r_dr     <= '0;
         r_wrdata <= '0;
         r_rr     <= '0;
      end else begin
         r_gnt    <= w_nxt_gnt;
         r_write  <= w_nxt_write;
         r_dr     <= w_nxt_dr;
         r_wrdata <= w_nxt_wrdata;
         r_rr     <= w_nxt_rr;
      end
   end

endmodule
